// File: rtl/ahb_dma_pkg.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module  : ahb_dma_pkg
// Brief   : Shared FSM state encoding and AHB-lite constants for ahb_dma_master
// Revision: 1.0 - initial release
// ============================================================================
package ahb_dma_pkg;

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_RD_A = 3'd1,
    ST_RD_D = 3'd2,
    ST_WR_A = 3'd3,
    ST_WR_D = 3'd4,
    ST_DONE = 3'd5
  } dma_state_t;

  localparam logic [1:0] HTRANS_IDLE   = 2'b00;
  localparam logic [1:0] HTRANS_NONSEQ = 2'b10;
  localparam logic [2:0] HSIZE_WORD    = 3'b010;

endpackage
`default_nettype wire

// File: rtl/ahb_dma_master.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module  : ahb_dma_master
// Brief   : Word-by-word AHB-lite memory copy engine (read, then write, per word).
//           Define AHB_DMA_IRQ_EN to add the sticky irq output and irq_clr input.
// Revision: 1.0 - initial release
// ============================================================================
module ahb_dma_master
  import ahb_dma_pkg::*;
#(
  parameter int CNT_W = 16
) (
  input  logic             HCLK,
  input  logic             HRESET,
  input  logic             start,
  input  logic [31:0]      src_addr,
  input  logic [31:0]      dst_addr,
  input  logic [CNT_W-1:0] word_cnt,
  output logic             busy,
  output logic             done,
  output logic             err,
`ifdef AHB_DMA_IRQ_EN
  output logic             irq,
  input  logic             irq_clr,
`endif
  output logic [31:0]      HADDR,
  output logic [1:0]       HTRANS,
  output logic             HWRITE,
  output logic [2:0]       HSIZE,
  output logic [31:0]      HWDATA,
  input  logic             HREADY,
  input  logic [31:0]      HRDATA,
  input  logic             HRESP
);

  dma_state_t       r_state;
  dma_state_t       w_next;
  logic [31:0]      r_src;
  logic [31:0]      r_dst;
  logic [31:0]      r_data;
  logic [CNT_W-1:0] r_cnt;
  logic             r_err;

  logic             w_accept;
  logic             w_rd_ok;
  logic             w_wr_ok;
  logic             w_bus_err;
  logic [3:0]       w_unused_addr_lsb;

  assign w_accept  = (r_state == ST_IDLE) && start;
  assign w_rd_ok   = (r_state == ST_RD_D) && HREADY && !HRESP;
  assign w_wr_ok   = (r_state == ST_WR_D) && HREADY && !HRESP;
  assign w_bus_err = HREADY && HRESP && ((r_state == ST_RD_D) || (r_state == ST_WR_D));
  // Byte-lane bits are discarded: every transfer is word aligned.
  assign w_unused_addr_lsb = {src_addr[1:0], dst_addr[1:0]};

  always_ff @(posedge HCLK) begin
    if (HRESET) r_state <= ST_IDLE;
    else        r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      ST_IDLE: if (start)  w_next = (word_cnt == '0) ? ST_DONE : ST_RD_A;
      ST_RD_A: if (HREADY) w_next = ST_RD_D;
      ST_RD_D: if (HREADY) w_next = HRESP ? ST_DONE : ST_WR_A;
      ST_WR_A: if (HREADY) w_next = ST_WR_D;
      // r_cnt still holds the pre-decrement value here, so 1 means last word.
      ST_WR_D: if (HREADY) w_next = (HRESP || (r_cnt == CNT_W'(1))) ? ST_DONE : ST_RD_A;
      ST_DONE: w_next = ST_IDLE;
      default: w_next = ST_IDLE;
    endcase
  end

  always_comb begin
    HTRANS = HTRANS_IDLE;
    HADDR  = '0;
    HWRITE = 1'b0;
    HSIZE  = HSIZE_WORD;
    HWDATA = '0;
    busy   = (r_state != ST_IDLE);
    done   = (r_state == ST_DONE);
    err    = r_err;
    case (r_state)
      ST_RD_A: begin
        HTRANS = HTRANS_NONSEQ;
        HADDR  = r_src;
      end
      ST_WR_A: begin
        HTRANS = HTRANS_NONSEQ;
        HADDR  = r_dst;
        HWRITE = 1'b1;
      end
      ST_WR_D: HWDATA = r_data;
      default: ;
    endcase
  end

  always_ff @(posedge HCLK) begin
    if (HRESET) begin
      r_src  <= '0;
      r_dst  <= '0;
      r_cnt  <= '0;
      r_data <= '0;
      r_err  <= 1'b0;
    end else begin
      if (w_accept) begin
        r_src <= {src_addr[31:2], 2'b00};
        r_dst <= {dst_addr[31:2], 2'b00};
        r_cnt <= word_cnt;
        r_err <= 1'b0;
      end
      if (w_rd_ok) r_data <= HRDATA;
      if (w_wr_ok) begin
        r_src <= r_src + 32'd4;
        r_dst <= r_dst + 32'd4;
        r_cnt <= r_cnt - CNT_W'(1);
      end
      if (w_bus_err) r_err <= 1'b1;
    end
  end

`ifdef AHB_DMA_IRQ_EN
  logic r_irq;

  // Clear has priority so software never loses an acknowledge.
  always_ff @(posedge HCLK) begin
    if (HRESET)                  r_irq <= 1'b0;
    else if (irq_clr)            r_irq <= 1'b0;
    else if (r_state == ST_DONE) r_irq <= 1'b1;
  end

  assign irq = r_irq;
`endif

endmodule
`default_nettype wire

// File: tb/tb_ahb_dma_master.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module  : tb_ahb_dma_master
// Brief   : Directed self-checking bench for ahb_dma_master with a small AHB slave.
// Revision: 1.0 - initial release
// ============================================================================
module tb_ahb_dma_master;

  logic        HCLK = 1'b0;
  logic        HRESET = 1'b1;
  logic        start = 1'b0;
  logic [31:0] src_addr = '0;
  logic [31:0] dst_addr = '0;
  logic [15:0] word_cnt = '0;
  logic        busy, done, err;
  logic [31:0] HADDR, HWDATA, HRDATA;
  logic [1:0]  HTRANS;
  logic        HWRITE, HREADY, HRESP;
  logic [2:0]  HSIZE;
`ifdef AHB_DMA_IRQ_EN
  logic        irq;
  logic        irq_clr = 1'b0;
`endif

  int n_tests = 0;
  int n_fail  = 0;

  // Slave model: read data is the address XOR a fixed tag.
  logic        dp_valid = 1'b0;
  logic        dp_write = 1'b0;
  logic [31:0] dp_addr  = '0;
  int          wait_left = 0;
  int          rd_waits = 0;
  int          err_on_read = 0;
  int          rd_count = 0;
  int          nonseq_seen = 0;
  int          bad_hwdata = 0;
  logic        clr_log = 1'b0;
  logic [31:0] addr_log[$];
  logic [31:0] wr_data_log[$];

  assign HREADY = (wait_left == 0);
  assign HRDATA = (dp_valid && !dp_write) ? (dp_addr ^ 32'hCAFE_0000) : 32'h0;
  assign HRESP  = dp_valid && !dp_write && (rd_count == err_on_read);

  ahb_dma_master #(.CNT_W(16)) dut (
    .HCLK(HCLK), .HRESET(HRESET), .start(start),
    .src_addr(src_addr), .dst_addr(dst_addr), .word_cnt(word_cnt),
    .busy(busy), .done(done), .err(err),
`ifdef AHB_DMA_IRQ_EN
    .irq(irq), .irq_clr(irq_clr),
`endif
    .HADDR(HADDR), .HTRANS(HTRANS), .HWRITE(HWRITE), .HSIZE(HSIZE),
    .HWDATA(HWDATA), .HREADY(HREADY), .HRDATA(HRDATA), .HRESP(HRESP)
  );

  always #5 HCLK = ~HCLK;

  always @(posedge HCLK) begin
    if (clr_log) begin
      addr_log.delete();
      wr_data_log.delete();
      rd_count = 0;
      nonseq_seen = 0;
    end
    if (HRESET) begin
      dp_valid  <= 1'b0;
      wait_left <= 0;
    end else begin
      if (wait_left > 0) wait_left <= wait_left - 1;
      if (HTRANS != 2'b00) nonseq_seen++;
      if (!(dp_valid && dp_write) && HWDATA != 32'h0) bad_hwdata++;
      if (HREADY) begin
        if (dp_valid && dp_write) wr_data_log.push_back(HWDATA);
        if (HTRANS == 2'b10) begin
          dp_valid <= 1'b1;
          dp_addr  <= HADDR;
          dp_write <= HWRITE;
          addr_log.push_back(HADDR);
          if (!HWRITE) begin
            rd_count++;
            wait_left <= rd_waits;
          end
        end else begin
          dp_valid <= 1'b0;
        end
      end
    end
  end

  task automatic clear_logs();
    clr_log = 1'b1;
    @(posedge HCLK); #1;
    clr_log = 1'b0;
  endtask

  // Pulses start; returns the cycle (start edge = 0) at which done is seen, -1 on timeout.
  task automatic run_xfer(input logic [31:0] s, input logic [31:0] d,
                          input logic [15:0] c, output int dc);
    src_addr = s; dst_addr = d; word_cnt = c; start = 1'b1;
    @(posedge HCLK); #1;
    start = 1'b0;
    dc = -1;
    for (int cyc = 1; cyc <= 200; cyc++) begin
      if (done) begin dc = cyc; break; end
      @(posedge HCLK); #1;
    end
  endtask

  task automatic test_reset();
    HRESET = 1'b1;
    repeat (2) @(posedge HCLK);
    #1;
    n_tests++; if (HTRANS !== 2'b00) begin n_fail++; $display("FAIL reset_htrans got %0h want 0", HTRANS); end
    n_tests++; if (HADDR !== 32'h0) begin n_fail++; $display("FAIL reset_haddr got %08h want 0", HADDR); end
    n_tests++; if (HWRITE !== 1'b0 || HSIZE !== 3'b010) begin n_fail++; $display("FAIL reset_ctrl hwrite=%0b hsize=%0h want 0/2", HWRITE, HSIZE); end
    n_tests++; if (HWDATA !== 32'h0) begin n_fail++; $display("FAIL reset_hwdata got %08h want 0", HWDATA); end
    n_tests++; if ({busy, done, err} !== 3'b000) begin n_fail++; $display("FAIL reset_status busy/done/err got %03b want 000", {busy, done, err}); end
`ifdef AHB_DMA_IRQ_EN
    n_tests++; if (irq !== 1'b0) begin n_fail++; $display("FAIL reset_irq got %0b want 0", irq); end
`endif
    HRESET = 1'b0;
    @(posedge HCLK); #1;
  endtask

  task automatic test_basic_copy();
    int dc;
    logic [31:0] exp_a [6] = '{32'h100, 32'h200, 32'h104, 32'h204, 32'h108, 32'h208};
    logic [31:0] exp_d [3] = '{32'hCAFE_0100, 32'hCAFE_0104, 32'hCAFE_0108};
    clear_logs();
    rd_waits = 0; err_on_read = 0;
    run_xfer(32'h100, 32'h200, 16'd3, dc);
    n_tests++; if (dc != 13) begin n_fail++; $display("FAIL basic_done_cycle got %0d want 13", dc); end
    n_tests++; if (addr_log.size() != 6) begin n_fail++; $display("FAIL basic_addr_count got %0d want 6", addr_log.size()); end
    else for (int i = 0; i < 6; i++) begin
      n_tests++; if (addr_log[i] !== exp_a[i]) begin n_fail++; $display("FAIL basic_haddr[%0d] got %08h want %08h", i, addr_log[i], exp_a[i]); end
    end
    n_tests++; if (wr_data_log.size() != 3) begin n_fail++; $display("FAIL basic_write_count got %0d want 3", wr_data_log.size()); end
    else for (int i = 0; i < 3; i++) begin
      n_tests++; if (wr_data_log[i] !== exp_d[i]) begin n_fail++; $display("FAIL basic_hwdata[%0d] got %08h want %08h", i, wr_data_log[i], exp_d[i]); end
    end
    @(posedge HCLK); #1;
    n_tests++; if (done !== 1'b0 || busy !== 1'b0) begin n_fail++; $display("FAIL basic_done_width done=%0b busy=%0b want 0/0", done, busy); end
  endtask

  task automatic test_wait_states();
    int dc;
    clear_logs();
    rd_waits = 2; err_on_read = 0;
    run_xfer(32'h100, 32'h200, 16'd3, dc);
    // 12 zero-wait bus cycles + 2 waits in each of 3 reads, DONE one cycle later.
    n_tests++; if (dc != 19) begin n_fail++; $display("FAIL wait_done_cycle got %0d want 19", dc); end
    n_tests++; if (nonseq_seen != 6) begin n_fail++; $display("FAIL wait_nonseq_cycles got %0d want 6", nonseq_seen); end
    n_tests++; if (wr_data_log.size() != 3) begin n_fail++; $display("FAIL wait_write_count got %0d want 3", wr_data_log.size()); end
    else begin
      n_tests++; if (wr_data_log[2] !== 32'hCAFE_0108) begin n_fail++; $display("FAIL wait_hwdata2 got %08h want cafe0108", wr_data_log[2]); end
    end
    rd_waits = 0;
    @(posedge HCLK); #1;
  endtask

  task automatic test_zero_count();
    int dc;
    clear_logs();
    run_xfer(32'h100, 32'h200, 16'd0, dc);
    n_tests++; if (dc != 1) begin n_fail++; $display("FAIL zero_done_cycle got %0d want 1", dc); end
    n_tests++; if (nonseq_seen != 0) begin n_fail++; $display("FAIL zero_bus_activity got %0d want 0", nonseq_seen); end
    @(posedge HCLK); #1;
    n_tests++; if (busy !== 1'b0 || done !== 1'b0) begin n_fail++; $display("FAIL zero_return_idle busy=%0b done=%0b want 0/0", busy, done); end
  endtask

  task automatic test_bus_error();
    int dc;
    clear_logs();
    err_on_read = 2;
    run_xfer(32'h100, 32'h200, 16'd3, dc);
    n_tests++; if (dc != 7) begin n_fail++; $display("FAIL err_done_cycle got %0d want 7", dc); end
    n_tests++; if (err !== 1'b1) begin n_fail++; $display("FAIL err_flag got %0b want 1", err); end
    n_tests++; if (wr_data_log.size() != 1) begin n_fail++; $display("FAIL err_write_count got %0d want 1", wr_data_log.size()); end
    n_tests++; if (addr_log.size() != 3) begin n_fail++; $display("FAIL err_access_count got %0d want 3", addr_log.size()); end
    err_on_read = 0;
    @(posedge HCLK); #1;
    n_tests++; if (err !== 1'b1 || busy !== 1'b0) begin n_fail++; $display("FAIL err_sticky err=%0b busy=%0b want 1/0", err, busy); end
    run_xfer(32'h100, 32'h200, 16'd0, dc);
    n_tests++; if (err !== 1'b0 || dc != 1) begin n_fail++; $display("FAIL err_clear_on_start err=%0b dc=%0d want 0/1", err, dc); end
    @(posedge HCLK); #1;
  endtask

  task automatic test_addr_wrap();
    int dc;
    clear_logs();
    run_xfer(32'hFFFF_FFFC, 32'h10, 16'd2, dc);
    n_tests++; if (dc != 9) begin n_fail++; $display("FAIL wrap_done_cycle got %0d want 9", dc); end
    n_tests++; if (addr_log.size() != 4) begin n_fail++; $display("FAIL wrap_access_count got %0d want 4", addr_log.size()); end
    else begin
      n_tests++; if (addr_log[2] !== 32'h0) begin n_fail++; $display("FAIL wrap_second_read got %08h want 00000000", addr_log[2]); end
      n_tests++; if (addr_log[3] !== 32'h14) begin n_fail++; $display("FAIL wrap_second_write got %08h want 00000014", addr_log[3]); end
    end
    n_tests++; if (wr_data_log.size() != 2) begin n_fail++; $display("FAIL wrap_write_count got %0d want 2", wr_data_log.size()); end
    else begin
      n_tests++; if (wr_data_log[0] !== 32'h3501_FFFC || wr_data_log[1] !== 32'hCAFE_0000) begin
        n_fail++; $display("FAIL wrap_hwdata got %08h/%08h want 3501fffc/cafe0000", wr_data_log[0], wr_data_log[1]); end
    end
    @(posedge HCLK); #1;
  endtask

  task automatic test_start_ignored();
    int dc;
    clear_logs();
    src_addr = 32'h303; dst_addr = 32'h402; word_cnt = 16'd1; start = 1'b1;
    @(posedge HCLK); #1;
    start = 1'b0;
    @(posedge HCLK); #1;
    src_addr = 32'h800; dst_addr = 32'h900; word_cnt = 16'd5; start = 1'b1;
    @(posedge HCLK); #1;
    start = 1'b0;
    dc = -1;
    for (int cyc = 3; cyc <= 200; cyc++) begin
      if (done) begin dc = cyc; break; end
      @(posedge HCLK); #1;
    end
    n_tests++; if (dc != 5) begin n_fail++; $display("FAIL ignore_done_cycle got %0d want 5", dc); end
    n_tests++; if (addr_log.size() != 2) begin n_fail++; $display("FAIL ignore_access_count got %0d want 2", addr_log.size()); end
    else begin
      n_tests++; if (addr_log[0] !== 32'h300 || addr_log[1] !== 32'h400) begin
        n_fail++; $display("FAIL ignore_aligned_addr got %08h/%08h want 00000300/00000400", addr_log[0], addr_log[1]); end
    end
    @(posedge HCLK); #1;
  endtask

  task automatic test_reset_midway();
    src_addr = 32'h100; dst_addr = 32'h200; word_cnt = 16'd3; start = 1'b1;
    @(posedge HCLK); #1;
    start = 1'b0;
    repeat (2) @(posedge HCLK);
    #1;
    n_tests++; if (HTRANS !== 2'b10 || HWRITE !== 1'b1 || HADDR !== 32'h200) begin
      n_fail++; $display("FAIL midrst_in_wr_a htrans=%0h hwrite=%0b haddr=%08h want 2/1/00000200", HTRANS, HWRITE, HADDR); end
    HRESET = 1'b1;
    @(posedge HCLK); #1;
    n_tests++; if (HTRANS !== 2'b00 || busy !== 1'b0 || HADDR !== 32'h0) begin
      n_fail++; $display("FAIL midrst_idle htrans=%0h busy=%0b haddr=%08h want 0/0/0", HTRANS, busy, HADDR); end
    HRESET = 1'b0;
    @(posedge HCLK); #1;
    n_tests++; if (busy !== 1'b0 || done !== 1'b0) begin n_fail++; $display("FAIL midrst_stays_idle busy=%0b done=%0b want 0/0", busy, done); end
  endtask

`ifdef AHB_DMA_IRQ_EN
  task automatic test_irq();
    int dc;
    irq_clr = 1'b1;
    @(posedge HCLK); #1;
    irq_clr = 1'b0;
    run_xfer(32'h100, 32'h200, 16'd0, dc);
    @(posedge HCLK); #1;
    n_tests++; if (irq !== 1'b1) begin n_fail++; $display("FAIL irq_set got %0b want 1", irq); end
    repeat (3) @(posedge HCLK);
    #1;
    n_tests++; if (irq !== 1'b1) begin n_fail++; $display("FAIL irq_hold got %0b want 1", irq); end
    irq_clr = 1'b1;
    @(posedge HCLK); #1;
    irq_clr = 1'b0;
    n_tests++; if (irq !== 1'b0) begin n_fail++; $display("FAIL irq_clear got %0b want 0", irq); end
    run_xfer(32'h100, 32'h200, 16'd0, dc);
    irq_clr = 1'b1;
    @(posedge HCLK); #1;
    irq_clr = 1'b0;
    n_tests++; if (irq !== 1'b0) begin n_fail++; $display("FAIL irq_clr_priority got %0b want 0", irq); end
  endtask
`endif

  initial begin
    test_reset();
    test_basic_copy();
    test_wait_states();
    test_zero_count();
    test_bus_error();
    test_addr_wrap();
    test_start_ignored();
    test_reset_midway();
`ifdef AHB_DMA_IRQ_EN
    test_irq();
`endif
    n_tests++; if (bad_hwdata != 0) begin n_fail++; $display("FAIL hwdata_outside_wr_d got %0d cycles want 0", bad_hwdata); end
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
